// File: rtl/spi_pkg.sv
// Shared types for the configurable SPI master: FSM states and the latched mode word.
package spi_pkg;

  localparam int unsigned MAX_NCS = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    DONE
  } spi_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

endpackage

// File: rtl/spi_clkgen.sv
// sclk generator: divides clk by DIV per half-period while enabled and flags
// leading/trailing edges one cycle ahead of the sclk register update.
module spi_clkgen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic load,
  input  logic load_val,
  output logic sclk,
  output logic lead_c,
  output logic trail_c
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic          sclk_q, sclk_d;
  logic          tick;

  always_comb begin
    tick    = en && (cnt_q == CW'(DIV - 1));
    cnt_d   = (en && !tick) ? cnt_q + CW'(1) : '0;
    phase_d = en ? (phase_q ^ tick) : 1'b0;
    sclk_d  = sclk_q;
    if (load) begin
      sclk_d = load_val;
    end else if (tick) begin
      sclk_d = ~sclk_q;
    end
    // Even half-periods open a bit (leading), odd ones close it (trailing).
    lead_c  = tick & ~phase_q;
    trail_c = tick & phase_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
      sclk_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      sclk_q  <= sclk_d;
    end
  end

  assign sclk = sclk_q;

endmodule

// File: rtl/spi_master_cfg.sv
// Full-duplex SPI master with runtime mode, selectable chip select and
// configurable width, divider and bit order.
module spi_master_cfg #(
  parameter int unsigned DW        = 12,
  parameter int unsigned NCS       = 2,
  parameter int unsigned DIV       = 4,
  parameter int unsigned LSB_FIRST = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                newd,
  input  logic [DW-1:0]                       din,
  input  logic [1:0]                          mode,
  input  logic [((NCS > 1) ? $clog2(NCS) : 1)-1:0] cs_sel,
  input  logic                                miso,
  output logic                                sclk,
  output logic [NCS-1:0]                      cs_n,
  output logic                                mosi,
  output logic [DW-1:0]                       dout,
  output logic                                done,
  output logic                                busy,
  output logic                                sel_err
);

  import spi_pkg::*;

  localparam int unsigned CSW  = (NCS > 1) ? $clog2(NCS) : 1;
  localparam int unsigned NSEL = 1 << CSW;
  localparam int unsigned BW   = $clog2(DW);
  localparam int unsigned HW   = (DIV > 1) ? $clog2(DIV) : 1;

  spi_state_e    state_q, state_d;
  logic          cpha_q, cpha_d;
  logic [DW-1:0] tx_q, tx_d;
  logic [DW-1:0] rx_q, rx_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [NCS-1:0] cs_n_q, cs_n_d;
  logic          mosi_q, mosi_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          sel_err_q, sel_err_d;

  spi_mode_t     mode_in;
  logic [NSEL-1:0] sel_ok;
  logic          accept;
  logic          lead_c, trail_c;
  logic          sample_c, shift_c;

  function automatic logic first_bit(input logic [DW-1:0] w);
    return (LSB_FIRST != 0) ? w[0] : w[DW-1];
  endfunction

  function automatic logic [DW-1:0] shift_out(input logic [DW-1:0] w);
    return (LSB_FIRST != 0) ? (w >> 1) : (w << 1);
  endfunction

  function automatic logic [DW-1:0] shift_in(input logic [DW-1:0] w, input logic b);
    return (LSB_FIRST != 0) ? {b, w[DW-1:1]} : {w[DW-2:0], b};
  endfunction

  assign mode_in = spi_mode_t'(mode);

  // Encodings of cs_sel that address a real slave.
  always_comb begin
    sel_ok = '0;
    for (int unsigned i = 0; i < NSEL; i++) begin
      sel_ok[i] = (i < NCS);
    end
  end

  spi_clkgen #(
    .DIV(DIV)
  ) u_clkgen (
    .clk     (clk),
    .rst     (rst),
    .en      (state_q == XFER),
    .load    (accept),
    .load_val(mode_in.cpol),
    .sclk    (sclk),
    .lead_c  (lead_c),
    .trail_c (trail_c)
  );

  always_comb begin
    state_d   = state_q;
    cpha_d    = cpha_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    bit_d     = bit_q;
    hcnt_d    = hcnt_q;
    cs_n_d    = cs_n_q;
    mosi_d    = mosi_q;
    dout_d    = dout_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    sel_err_d = 1'b0;
    accept    = 1'b0;
    sample_c  = cpha_q ? trail_c : lead_c;
    shift_c   = cpha_q ? lead_c : trail_c;

    case (state_q)
      IDLE: begin
        if (newd) begin
          if (sel_ok[cs_sel]) begin
            accept  = 1'b1;
            state_d = SETUP;
            busy_d  = 1'b1;
            cpha_d  = mode_in.cpha;
            hcnt_d  = '0;
            bit_d   = '0;
            rx_d    = '0;
            cs_n_d  = ~(NCS'(1) << cs_sel);
            // CPHA=0 presents the first bit before the first sclk edge.
            if (mode_in.cpha) begin
              tx_d   = din;
              mosi_d = 1'b0;
            end else begin
              tx_d   = shift_out(din);
              mosi_d = first_bit(din);
            end
          end else begin
            sel_err_d = 1'b1;
          end
        end
      end
      SETUP: begin
        if (hcnt_q == HW'(DIV - 1)) begin
          hcnt_d  = '0;
          state_d = XFER;
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      XFER: begin
        if (sample_c) begin
          rx_d = shift_in(rx_q, miso);
        end
        if (shift_c) begin
          mosi_d = first_bit(tx_q);
          tx_d   = shift_out(tx_q);
        end
        if (trail_c) begin
          if (bit_q == BW'(DW - 1)) begin
            state_d = HOLD;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      HOLD: begin
        if (hcnt_q == HW'(DIV - 1)) begin
          hcnt_d  = '0;
          state_d = DONE;
          cs_n_d  = '1;
          mosi_d  = 1'b0;
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      DONE: begin
        dout_d  = rx_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cpha_q    <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      bit_q     <= '0;
      hcnt_q    <= '0;
      cs_n_q    <= '1;
      mosi_q    <= 1'b0;
      dout_q    <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cpha_q    <= cpha_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      bit_q     <= bit_d;
      hcnt_q    <= hcnt_d;
      cs_n_q    <= cs_n_d;
      mosi_q    <= mosi_d;
      dout_q    <= dout_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign cs_n    = cs_n_q;
  assign mosi    = mosi_q;
  assign dout    = dout_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign sel_err = sel_err_q;

endmodule

// File: tb/tb_spi_master_cfg.sv
// Directed bench for spi_master_cfg: loopback default instance, MSB-first
// instance with a shift-register slave, and a three-slave instance.
module tb_spi_master_cfg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic rst;

  // Default instance, miso looped back from mosi.
  logic        newd_a;
  logic [11:0] din_a;
  logic [1:0]  mode_a;
  logic [0:0]  sel_a;
  logic        sclk_a, mosi_a, done_a, busy_a, err_a;
  logic [1:0]  csn_a;
  logic [11:0] dout_a;

  spi_master_cfg #(.DW(12), .NCS(2), .DIV(4), .LSB_FIRST(1)) u_a (
    .clk(clk), .rst(rst), .newd(newd_a), .din(din_a), .mode(mode_a),
    .cs_sel(sel_a), .miso(mosi_a), .sclk(sclk_a), .cs_n(csn_a),
    .mosi(mosi_a), .dout(dout_a), .done(done_a), .busy(busy_a),
    .sel_err(err_a)
  );

  // MSB-first instance against a slave shifting out 12'h81F.
  logic        newd_b;
  logic [11:0] din_b;
  logic [1:0]  mode_b;
  logic [0:0]  sel_b;
  logic        sclk_b, mosi_b, miso_b, done_b, busy_b, err_b;
  logic [1:0]  csn_b;
  logic [11:0] dout_b;

  spi_master_cfg #(.DW(12), .NCS(2), .DIV(4), .LSB_FIRST(0)) u_b (
    .clk(clk), .rst(rst), .newd(newd_b), .din(din_b), .mode(mode_b),
    .cs_sel(sel_b), .miso(miso_b), .sclk(sclk_b), .cs_n(csn_b),
    .mosi(mosi_b), .dout(dout_b), .done(done_b), .busy(busy_b),
    .sel_err(err_b)
  );

  // Three chip-select instance.
  logic        newd_c;
  logic [11:0] din_c;
  logic [1:0]  mode_c;
  logic [1:0]  sel_c;
  logic        sclk_c, mosi_c, done_c, busy_c, err_c;
  logic [2:0]  csn_c;
  logic [11:0] dout_c;

  spi_master_cfg #(.DW(12), .NCS(3), .DIV(4), .LSB_FIRST(1)) u_c (
    .clk(clk), .rst(rst), .newd(newd_c), .din(din_c), .mode(mode_c),
    .cs_sel(sel_c), .miso(mosi_c), .sclk(sclk_c), .cs_n(csn_c),
    .mosi(mosi_c), .dout(dout_c), .done(done_c), .busy(busy_c),
    .sel_err(err_c)
  );

  // Mode-0 slave: presents word MSB-first, advancing on each falling sclk.
  logic [11:0] slv_word = 12'h81F;
  int          fall_b   = 0;
  always @(negedge sclk_b or posedge csn_b[0]) begin
    if (csn_b[0]) fall_b <= 0;
    else          fall_b <= fall_b + 1;
  end
  assign miso_b = (fall_b < 12) ? slv_word[4'(11 - fall_b)] : 1'b0;

  logic [11:0] cap_b = '0;
  always @(posedge sclk_b) cap_b <= {cap_b[10:0], mosi_b};

  int rise_a = 0;
  always @(posedge sclk_a) rise_a <= rise_a + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a(input logic [11:0] d, input logic [1:0] m, input logic s);
    newd_a = 1'b1;
    din_a  = d;
    mode_a = m;
    sel_a  = s;
    tick();
    newd_a = 1'b0;
  endtask

  // Cycles from the accept edge until done is seen; 400 means it never came.
  task automatic wait_done_a(output int n);
    n = 0;
    while (n < 400) begin
      tick();
      n++;
      if (done_a) break;
    end
  endtask

  int n;
  int r0;
  int dones;
  logic [1:0] mm;

  initial begin
    rst = 1'b1;
    newd_a = 1'b0; din_a = '0; mode_a = '0; sel_a = '0;
    newd_b = 1'b0; din_b = '0; mode_b = '0; sel_b = '0;
    newd_c = 1'b0; din_c = '0; mode_c = '0; sel_c = '0;
    tick();
    tick();
    check("rst_sclk", 32'(sclk_a), 32'h0);
    check("rst_csn", 32'(csn_a), 32'h3);
    check("rst_mosi", 32'(mosi_a), 32'h0);
    check("rst_dout", 32'(dout_a), 32'h0);
    check("rst_flags", {29'h0, done_a, busy_a, err_a}, 32'h0);
    rst = 1'b0;
    tick();

    // Abort mid-transfer (mode 2 so idle sclk is 1 before the reset).
    start_a(12'h5A3, 2'b10, 1'b0);
    check("abort_busy", 32'(busy_a), 32'h1);
    check("abort_csn", 32'(csn_a), 32'h2);
    check("abort_sclk_cpol", 32'(sclk_a), 32'h1);
    repeat (4 + 6 * 8 + 2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_csn_after", 32'(csn_a), 32'h3);
    check("abort_sclk_after", 32'(sclk_a), 32'h0);
    check("abort_busy_after", 32'(busy_a), 32'h0);
    check("abort_dout_after", 32'(dout_a), 32'h0);
    dones = 0;
    repeat (150) begin
      tick();
      if (done_a) dones++;
    end
    check("abort_no_done", 32'(dones), 32'h0);

    // Mode 0, slave 1.
    r0 = rise_a;
    start_a(12'hA5C, 2'b00, 1'b1);
    check("m0_csn", 32'(csn_a), 32'h1);
    check("m0_busy", 32'(busy_a), 32'h1);
    wait_done_a(n);
    check("m0_latency", 32'(n), 32'd105);
    check("m0_dout", 32'(dout_a), 32'hA5C);
    check("m0_rises", 32'(rise_a - r0), 32'd12);
    check("m0_csn_end", 32'(csn_a), 32'h3);
    tick();
    check("m0_done_pulse", 32'(done_a), 32'h0);
    check("m0_busy_end", 32'(busy_a), 32'h0);

    // Modes 1..3.
    for (int m = 1; m < 4; m++) begin
      mm = 2'(m);
      start_a(12'h3C5, mm, 1'b0);
      check("mx_sclk_setup", 32'(sclk_a), 32'(mm[1]));
      wait_done_a(n);
      check("mx_latency", 32'(n), 32'd105);
      check("mx_dout", 32'(dout_a), 32'h3C5);
      tick();
      check("mx_sclk_idle", 32'(sclk_a), 32'(mm[1]));
    end

    // newd held through busy, then accepted on the cycle after done.
    newd_a = 1'b1; din_a = 12'h0F0; mode_a = 2'b00; sel_a = 1'b0;
    tick();
    din_a = 12'hFFF; mode_a = 2'b11; sel_a = 1'b1;
    check("b2b_csn_first", 32'(csn_a), 32'h2);
    wait_done_a(n);
    check("b2b_latency1", 32'(n), 32'd105);
    check("b2b_dout1", 32'(dout_a), 32'h0F0);
    tick();
    newd_a = 1'b0;
    check("b2b_busy2", 32'(busy_a), 32'h1);
    check("b2b_csn2", 32'(csn_a), 32'h1);
    check("b2b_dout_hold", 32'(dout_a), 32'h0F0);
    wait_done_a(n);
    check("b2b_latency2", 32'(n), 32'd105);
    check("b2b_dout2", 32'(dout_a), 32'hFFF);

    // MSB-first instance.
    newd_b = 1'b1; din_b = 12'hC36; mode_b = 2'b00; sel_b = 1'b0;
    tick();
    newd_b = 1'b0;
    n = 0;
    while (n < 400) begin
      tick();
      n++;
      if (done_b) break;
    end
    check("msb_latency", 32'(n), 32'd105);
    check("msb_dout", 32'(dout_b), 32'h81F);
    check("msb_mosi_order", 32'(cap_b), 32'hC36);

    // Out-of-range chip select on the three-slave instance.
    newd_c = 1'b1; sel_c = 2'd3; din_c = 12'h123;
    tick();
    newd_c = 1'b0;
    check("sel_err_pulse", 32'(err_c), 32'h1);
    check("sel_err_csn", 32'(csn_c), 32'h7);
    check("sel_err_busy", 32'(busy_c), 32'h0);
    tick();
    check("sel_err_clear", 32'(err_c), 32'h0);
    check("sel_err_idle", 32'(busy_c), 32'h0);
    newd_c = 1'b1; sel_c = 2'd2;
    tick();
    newd_c = 1'b0;
    check("sel2_csn", 32'(csn_c), 32'h3);
    check("sel2_busy", 32'(busy_c), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
